// File: rtl/fetch_pkg.sv
// Shared types and default parameter values for the fetch sequencer and its return-address stack.
package fetch_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StWait,
    StHalted
  } fetch_state_e;

  localparam int unsigned DefPcW      = 8;
  localparam int unsigned DefRasDepth = 4;
  localparam int unsigned DefPcStep   = 1;

endpackage

// File: rtl/return_addr_stack.sv
// Circular return-address stack: a push onto a full stack overwrites the oldest entry and
// sets a sticky overflow flag; a simultaneous push and pop replaces the top entry.
module return_addr_stack
  import fetch_pkg::*;
#(
  parameter int unsigned PC_W      = DefPcW,
  parameter int unsigned RAS_DEPTH = DefRasDepth
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] push_data,
  output logic [PC_W-1:0] top,
  output logic            empty,
  output logic            full,
  output logic            overflow
);

  localparam int unsigned PtrW = $clog2(RAS_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] Depth = CntW'(RAS_DEPTH);

  logic [PC_W-1:0] mem_q [RAS_DEPTH];
  logic [PC_W-1:0] mem_d [RAS_DEPTH];
  logic [PtrW-1:0] sp_q, sp_d, top_idx;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            ovf_q, ovf_d;

  // sp_q is the next free slot; the pointer width makes wrap-around automatic.
  assign top_idx  = sp_q - 1'b1;
  assign top      = mem_q[top_idx];
  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == Depth);
  assign overflow = ovf_q;

  always_comb begin
    mem_d = mem_q;
    sp_d  = sp_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (push && pop && !empty) begin
      mem_d[top_idx] = push_data;
    end else if (push) begin
      mem_d[sp_q] = push_data;
      sp_d        = sp_q + 1'b1;
      if (full) begin
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (pop && !empty) begin
      sp_d  = (cnt_q == CntW'(1)) ? '0 : top_idx;
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(RAS_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      sp_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      mem_q <= mem_d;
      sp_q  <= sp_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Program-counter sequencer with memory back-pressure, branch/jump/jal/jr redirects and halt.
// Define FETCH_SEQUENCER_RAS_EN to add a return-address stack that jr pops for its target.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned PC_W      = DefPcW,
  parameter int unsigned RAS_DEPTH = DefRasDepth,
  parameter int unsigned PC_STEP   = DefPcStep
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable_increment,
  input  logic            imem_ready,
  input  logic            halt,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  input  logic            jump,
  input  logic            jal,
  input  logic [PC_W-1:0] jump_target,
  input  logic            jr,
  input  logic [PC_W-1:0] jr_target,
  output logic [PC_W-1:0] pc,
  output logic            pc_valid,
  output logic [PC_W-1:0] link_addr,
  output logic            ras_empty,
  output logic            ras_full,
  output logic            ras_overflow
);

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, link_q, link_d;

  // Redirect controls captured when a request stalls into StWait.
  logic            jr_q, jr_d, jmp_q, jmp_d, jal_q, jal_d, br_q, br_d;
  logic [PC_W-1:0] bt_q, bt_d, jt_q, jt_d, jrt_q, jrt_d;

  logic            in_wait, adv;
  logic            sel_jr, sel_jmp, sel_jal, sel_br;
  logic [PC_W-1:0] sel_bt, sel_jt, sel_jrt, jr_tgt, pc_seq, pc_nxt;

  assign in_wait = (state_q == StWait);
  assign sel_jr  = in_wait ? jr_q  : jr;
  assign sel_jmp = in_wait ? jmp_q : jump;
  assign sel_jal = in_wait ? jal_q : jal;
  assign sel_br  = in_wait ? br_q  : branch_taken;
  assign sel_bt  = in_wait ? bt_q  : branch_target;
  assign sel_jt  = in_wait ? jt_q  : jump_target;
  assign sel_jrt = in_wait ? jrt_q : jr_target;

  // A stalled request is already accepted, so StWait only needs the memory handshake.
  assign adv    = ((state_q == StRun) && enable_increment && imem_ready) ||
                  (in_wait && imem_ready);
  assign pc_seq = pc_q + PC_W'(PC_STEP);

`ifdef FETCH_SEQUENCER_RAS_EN
  logic [PC_W-1:0] ras_top;

  return_addr_stack #(
    .PC_W      (PC_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (adv && sel_jal),
    .pop       (adv && sel_jr),
    .push_data (pc_seq),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full),
    .overflow  (ras_overflow)
  );

  assign jr_tgt = ras_empty ? sel_jrt : ras_top;
`else
  assign jr_tgt       = sel_jrt;
  assign ras_empty    = 1'b1;
  assign ras_full     = 1'b0;
  assign ras_overflow = 1'b0;
`endif

  always_comb begin
    if (sel_jr) begin
      pc_nxt = jr_tgt;
    end else if (sel_jmp || sel_jal) begin
      pc_nxt = sel_jt;
    end else if (sel_br) begin
      pc_nxt = sel_bt;
    end else begin
      pc_nxt = pc_seq;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    link_d  = link_q;
    jr_d    = jr_q;
    jmp_d   = jmp_q;
    jal_d   = jal_q;
    br_d    = br_q;
    bt_d    = bt_q;
    jt_d    = jt_q;
    jrt_d   = jrt_q;
    unique case (state_q)
      StIdle: state_d = StRun;
      StRun: begin
        if (halt) begin
          state_d = StHalted;
        end else if (enable_increment && !imem_ready) begin
          state_d = StWait;
          jr_d    = jr;
          jmp_d   = jump;
          jal_d   = jal;
          br_d    = branch_taken;
          bt_d    = branch_target;
          jt_d    = jump_target;
          jrt_d   = jr_target;
        end
      end
      StWait: begin
        if (imem_ready) begin
          state_d = StRun;
        end
      end
      StHalted: state_d = StHalted;
      default:  state_d = StIdle;
    endcase
    if (adv) begin
      pc_d = pc_nxt;
      if (sel_jal) begin
        link_d = pc_seq;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      pc_q    <= '0;
      link_q  <= '0;
      jr_q    <= 1'b0;
      jmp_q   <= 1'b0;
      jal_q   <= 1'b0;
      br_q    <= 1'b0;
      bt_q    <= '0;
      jt_q    <= '0;
      jrt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      link_q  <= link_d;
      jr_q    <= jr_d;
      jmp_q   <= jmp_d;
      jal_q   <= jal_d;
      br_q    <= br_d;
      bt_q    <= bt_d;
      jt_q    <= jt_d;
      jrt_q   <= jrt_d;
    end
  end

  assign pc        = pc_q;
  assign pc_valid  = (state_q == StRun) || (state_q == StWait);
  assign link_addr = link_q;

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter PC_W, default 8, program-counter/instruction-address width.
REQ-002 SHALL have parameter RAS_DEPTH, default 4, return-address-stack entries (power of two, 2..16).
REQ-003 SHALL have parameter PC_STEP, default 1, increment added to pc on sequential advance.
REQ-004 Ports, in order: clk in 1, the single clock; reset in 1, asynchronous active-low reset; enable_increment in 1, request to advance pc this cycle; imem_ready in 1, instruction memory accepts the address; halt in 1, stop fetching.
REQ-005 Ports: branch_taken in 1; branch_target in PC_W; jump in 1; jal in 1; jump_target in PC_W; jr in 1; jr_target in PC_W.
REQ-006 Ports: pc out PC_W, current fetch address; pc_valid out 1, pc is a live fetch request; link_addr out PC_W, pc+PC_STEP captured on jal; ras_empty out 1; ras_full out 1; ras_overflow out 1, sticky.

Function
REQ-007 SHALL implement FSM states IDLE, RUN, WAIT, HALTED.
REQ-008 IDLE: entered on reset; pc_valid=0; next cycle unconditionally goes to RUN.
REQ-009 RUN: pc_valid=1; if halt=1 go HALTED; else if enable_increment=1 and imem_ready=0 go WAIT; else stay RUN.
REQ-010 WAIT: pc_valid=1, pc held; on imem_ready=1 perform the stored advance and return to RUN; halt in WAIT takes effect only after that advance.
REQ-011 HALTED: pc_valid=0, pc held; leaves only via reset.
REQ-012 Advance occurs exactly when enable_increment=1 and imem_ready=1 in RUN or WAIT; pc updates on that clock edge (one-cycle latency).
REQ-013 Next-pc priority: jr, then jump/jal, then branch_taken, then pc+PC_STEP.
REQ-014 Redirect controls (jr, jump, jal, branch_taken, targets) SHALL be sampled on the cycle the request is accepted into WAIT and held internally; later changes during WAIT are ignored.
REQ-015 Arithmetic is modulo 2^PC_W; pc+PC_STEP wraps from max to low value without error.
REQ-016 On jal advance: link_addr<=pc+PC_STEP; return address pushed onto RAS (when enabled).
REQ-017 Simultaneous jr and jal on one advance: jr target selected, RAS pop then push (net top replaced by new link).

Reset
REQ-018 reset=0 SHALL asynchronously force: state IDLE, pc=0, pc_valid=0, link_addr=0, RAS pointer=0, ras_empty=1, ras_full=0, ras_overflow=0.
REQ-019 Reset during WAIT SHALL discard the pending advance; no RAS or pc update survives.

Configuration
REQ-020 Macro FETCH_SEQUENCER_RAS_EN: when defined, jr with ras_empty=0 SHALL pop the RAS and use the popped value instead of jr_target; jr with ras_empty=1 uses jr_target.
REQ-021 RAS push when full SHALL overwrite oldest entry (circular) and set ras_overflow until reset; pop when empty leaves pointer at 0.
REQ-022 When FETCH_SEQUENCER_RAS_EN undefined: no stack storage; jr always uses jr_target; ras_empty=1, ras_full=0, ras_overflow=0 constant.

Structure
REQ-023 Shared package fetch_pkg SHALL hold the FSM state enum and the default parameter constants.
REQ-024 RAS SHALL be a sub-module return_addr_stack (push, pop, top, empty, full, overflow), instantiated only under the macro.

Verification
REQ-025 Reset release, enable_increment=1, imem_ready=1 for 3 cycles -> pc 0 (invalid, IDLE), 0, 1, 2 with pc_valid=1 from cycle 2.
REQ-026 pc=5, enable_increment=1, imem_ready=0 two cycles, branch_taken=1 target 0x40 sampled then dropped -> pc holds 5, then 0x40 after imem_ready=1.
REQ-027 pc=0xFF, PC_W=8, sequential advance -> pc=0x00, no flag change.
REQ-028 RAS_EN, jal at pc=0x10 target 0x80, then jr with jr_target=0x33 -> link_addr=0x11, pc=0x80 then 0x11, ras_empty back to 1.
REQ-029 RAS_EN, RAS_DEPTH=4, five jal without jr -> ras_full=1, ras_overflow=1 and stays 1 until reset.
REQ-030 halt=1 in RUN, then enable_increment pulses -> pc_valid=0, pc frozen; reset=0 mid-WAIT -> pc=0, state IDLE immediately.
